// File: rtl/dmem_byte_ctrl_pkg.sv
// Shared op-size codes, FSM state encodings and lane helpers for dmem_byte_ctrl.
package dmem_byte_ctrl_pkg;

  localparam logic BAC_OP_WORD = 1'b0;
  localparam logic BAC_OP_BYTE = 1'b1;

  typedef enum logic [1:0] {
    DMC_IDLE = 2'd0,
    DMC_RD   = 2'd1,
    DMC_WR   = 2'd2,
    DMC_RESP = 2'd3
  } dmc_state_e;

  // Replace one byte lane of a word, leaving the other three untouched.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [7:0]  b,
                                             input logic [1:0]  lane);
    logic [31:0] w;
    w = word;
    w[8*lane +: 8] = b;
    return w;
  endfunction

  // Pick one byte lane and sign-extend it to 32 bits.
  function automatic logic [31:0] lane_sext(input logic [31:0] word,
                                            input logic [1:0]  lane);
    logic [7:0] b;
    b = word[8*lane +: 8];
    return {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/dmem_byte_ctrl_word_ram.sv
// Word-only RAM: synchronous write, registered synchronous read, no reset.
module word_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  // Write port and read-before-write registered read port.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_byte_ctrl.sv
// Data-memory responder: word/byte load/store over valid/ready against word RAM.
// Byte stores are read-modify-write; byte loads return the sign-extended lane.
module dmem_byte_ctrl
  import dmem_byte_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  dmc_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic                  size_q, size_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]            lane_q, lane_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  ram_we;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;

  // Index wraps modulo depth; upper address bits are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  // Next-state sequencing and request capture.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    err_d   = err_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    case (state_q)
      DMC_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          idx_d   = req_addr[ADDR_WIDTH+1:2];
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata;
          err_d   = (req_size == BAC_OP_WORD) && (req_addr[1:0] != 2'd0);
          if (err_d)                                 state_d = DMC_RESP;
          else if (req_we && req_size == BAC_OP_WORD) state_d = DMC_WR;
          else                                       state_d = DMC_RD;
        end
      end
      DMC_RD:   state_d = we_q ? DMC_WR : DMC_RESP;
      DMC_WR:   state_d = DMC_RESP;
      DMC_RESP: state_d = DMC_IDLE;
      default:  state_d = DMC_IDLE;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DMC_IDLE;
      we_q    <= 1'b0;
      size_q  <= BAC_OP_WORD;
      err_q   <= 1'b0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
    end
  end

  // RAM write path; reset in WR suppresses the write.
  always_comb begin
    ram_we    = (state_q == DMC_WR) && !rst;
    ram_wdata = (size_q == BAC_OP_BYTE) ? lane_merge(ram_rdata, wdata_q[7:0], lane_q)
                                        : wdata_q;
  end

  word_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (idx_q),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Handshake and response formatting; data/err are zero outside RESP.
  always_comb begin
    req_ready = (state_q == DMC_IDLE);
    rsp_valid = (state_q == DMC_RESP);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = 32'd0;
    if (rsp_valid && !we_q && !err_q)
      rsp_rdata = (size_q == BAC_OP_BYTE) ? lane_sext(ram_rdata, lane_q) : ram_rdata;
  end

endmodule

// File: tb/tb_dmem_byte_ctrl.sv
// Directed bench for dmem_byte_ctrl: vector table plus reset/busy sequences.
module tb_dmem_byte_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_size = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_byte_ctrl #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct {
    logic        we;
    logic        size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One request: accept, then wait (bounded) for the response pulse.
  task automatic run(input int id, input vec_t v);
    int k;
    @(negedge clk);
    chk($sformatf("v%0d ready_idle", id), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    k = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      k++;
      if (!rsp_valid)
        chk($sformatf("v%0d ready_busy", id), {31'd0, req_ready}, 32'd0);
    end while (!rsp_valid && k < 8);
    chk($sformatf("v%0d latency", id), k, v.lat);
    chk($sformatf("v%0d rdata", id), rsp_rdata, v.exp_rd);
    chk($sformatf("v%0d err", id), {31'd0, rsp_err}, {31'd0, v.exp_err});
  endtask

  initial begin
    vec_t v;
    //          we    size  addr          wdata         lat exp_rd        err
    vecs[0]  = '{1'b1, 1'b0, 32'h10,      32'hDEADBEEF, 2, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h10,      32'h0,        2, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h20,      32'h11223344, 2, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'h21,      32'hFFFFFFAA, 3, 32'h0,        1'b0};
    vecs[4]  = '{1'b1, 1'b1, 32'h23,      32'h00000055, 3, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h20,      32'h0,        2, 32'h5522AA44, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h30,      32'h80FF7F01, 2, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h30,      32'h0,        2, 32'h00000001, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h31,      32'h0,        2, 32'h0000007F, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h32,      32'h0,        2, 32'hFFFFFFFF, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h33,      32'h0,        2, 32'hFFFFFF80, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h04,      32'h13579BDF, 2, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h06,      32'h0,        1, 32'h0,        1'b1};
    vecs[13] = '{1'b1, 1'b0, 32'h05,      32'hFFFFFFFF, 1, 32'h0,        1'b1};
    vecs[14] = '{1'b0, 1'b0, 32'h04,      32'h0,        2, 32'h13579BDF, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 32'h1004,    32'hCAFEF00D, 2, 32'h0,        1'b0};
    vecs[16] = '{1'b0, 1'b0, 32'h0004,    32'h0,        2, 32'hCAFEF00D, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 32'hFFFF1007, 32'h0,       2, 32'hFFFFFFCA, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 32'h1004,    32'h0,        2, 32'h0000000D, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 32'h40,      32'h00000000, 2, 32'h0,        1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst ready", {31'd0, req_ready}, 32'd1);
    chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    chk("rst err", {31'd0, rsp_err}, 32'd0);

    for (int i = 0; i < 20; i++) run(i, vecs[i]);

    // Reset during WR of a byte store aborts the write and the response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 1'b1;
    req_addr = 32'h40; req_wdata = 32'h99;
    @(posedge clk);
    @(negedge clk);            // RD
    req_valid = 1'b0;
    chk("abort rd rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);            // WR
    chk("abort wr rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort idle ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort no_rsp%0d", i), {31'd0, rsp_valid}, 32'd0);
    end
    v = '{1'b0, 1'b0, 32'h40, 32'h0, 2, 32'h00000000, 1'b0};
    run(100, v);

    // req_valid held through busy; input changes while busy are ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 1'b0; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);            // RD of 0x10
    req_addr = 32'h30; req_we = 1'b1; req_wdata = 32'h0BAD0BAD;
    chk("hold rd ready", {31'd0, req_ready}, 32'd0);
    chk("hold rd rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);            // RESP of 0x10
    chk("hold resp valid", {31'd0, rsp_valid}, 32'd1);
    chk("hold resp rdata", rsp_rdata, 32'hDEADBEEF);
    chk("hold resp ready", {31'd0, req_ready}, 32'd0);
    req_we = 1'b0;             // IDLE edge accepts word load of 0x30
    @(negedge clk);            // IDLE
    chk("hold idle ready", {31'd0, req_ready}, 32'd1);
    chk("hold idle rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);            // RD of 0x30
    req_valid = 1'b0;
    chk("hold rd2 ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);            // RESP of 0x30
    chk("hold resp2 valid", {31'd0, rsp_valid}, 32'd1);
    chk("hold resp2 rdata", rsp_rdata, 32'h80FF7F01);
    @(negedge clk);
    chk("hold end ready", {31'd0, req_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
